// File: rtl/posit_quire_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : posit_quire_accum_if                                       |
// | Purpose  : Term-input and quire-output handshake bundle for the       |
// |            posit quire accumulator.                                  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface posit_quire_accum_if #(
  parameter int FRAC_W  = 32,
  parameter int QUIRE_W = 512,
  parameter int CNT_W   = 16
);
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic               in_sign;
  logic               in_zero;
  logic               in_inf;
  logic [7:0]         in_scale;
  logic [FRAC_W-1:0]  in_frac;
  logic               out_valid;
  logic               out_ready;
  logic [QUIRE_W-1:0] out_quire;
  logic               out_nar;
  logic [CNT_W-1:0]   out_count;

  // Producer of terms / consumer of the result
  modport master (
    output in_valid, in_last, in_sign, in_zero, in_inf, in_scale, in_frac, out_ready,
    input  in_ready, out_valid, out_quire, out_nar, out_count
  );

  // The accumulator itself
  modport slave (
    input  in_valid, in_last, in_sign, in_zero, in_inf, in_scale, in_frac, out_ready,
    output in_ready, out_valid, out_quire, out_nar, out_count
  );
endinterface
`default_nettype wire

// File: rtl/posit_quire_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : posit_quire_accum                                          |
// | Purpose  : Exact accumulation of decoded posit terms into a wide      |
// |            two's-complement fixed-point quire (dot-product sum).     |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module posit_quire_accum #(
  parameter int FRAC_W  = 32,
  parameter int QUIRE_W = 512,
  parameter int Q_FRAC  = 240,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  posit_quire_accum_if.slave   bus
);

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;
  logic   w_in_ready, w_out_valid;
  logic   w_in_xfer, w_out_xfer;

  // Stage 1: captured term fields
  logic              r_s1_valid, r_s1_sign, r_s1_zero, r_s1_inf;
  logic [7:0]        r_s1_scale;
  logic [FRAC_W-1:0] r_s1_frac;

  // Stage 2: aligned unsigned magnitude plus qualifiers
  logic               r_s2_valid, r_s2_sign, r_s2_kill, r_s2_nar;
  logic [QUIRE_W-1:0] r_s2_shifted;

  // Stage 3: signed addend ready for the quire
  logic               r_s3_valid, r_s3_nar;
  logic [QUIRE_W-1:0] r_s3_aligned;

  // Architectural result
  logic [QUIRE_W-1:0] r_quire;
  logic               r_nar;
  logic [CNT_W-1:0]   r_count;

  // Alignment arithmetic: w_pos is the quire bit the hidden one lands on
  logic signed [31:0] w_pos;
  logic               w_range_err;
  logic [QUIRE_W-1:0] w_mag, w_shifted;

  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = w_out_valid & bus.out_ready;

  assign w_pos       = Q_FRAC + 32'($signed(r_s1_scale));
  assign w_range_err = (w_pos >= (QUIRE_W - 2));
  assign w_mag       = {{(QUIRE_W-FRAC_W-1){1'b0}}, 1'b1, r_s1_frac};
  assign w_shifted   = (w_pos >= FRAC_W) ? (w_mag << (w_pos - FRAC_W))
                                         : (w_mag >> (FRAC_W - w_pos));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ACCUM;
    else       r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; DRAIN leaves once only the final addend remains
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ACCUM: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!r_s1_valid && !r_s2_valid) w_state_nxt = OUTPUT;
      end
      OUTPUT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = ACCUM;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  // Stage 1: register the accepted term
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_inf   <= 1'b0;
      r_s1_scale <= '0;
      r_s1_frac  <= '0;
    end else begin
      r_s1_valid <= w_in_xfer;
      if (w_in_xfer) begin
        r_s1_sign  <= bus.in_sign;
        r_s1_zero  <= bus.in_zero;
        r_s1_inf   <= bus.in_inf;
        r_s1_scale <= bus.in_scale;
        r_s1_frac  <= bus.in_frac;
      end
    end
  end

  // Stage 2: shift {1,frac} into quire position; out-of-range scales become NaR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign    <= 1'b0;
      r_s2_kill    <= 1'b0;
      r_s2_nar     <= 1'b0;
      r_s2_shifted <= '0;
    end else begin
      r_s2_valid   <= r_s1_valid;
      r_s2_sign    <= r_s1_sign;
      r_s2_kill    <= r_s1_zero | r_s1_inf | w_range_err;
      r_s2_nar     <= r_s1_inf | w_range_err;
      r_s2_shifted <= w_shifted;
    end
  end

  // Stage 3: apply sign, suppress zero/NaR contributions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s3_valid   <= 1'b0;
      r_s3_nar     <= 1'b0;
      r_s3_aligned <= '0;
    end else begin
      r_s3_valid   <= r_s2_valid;
      r_s3_nar     <= r_s2_nar;
      if (r_s2_kill)      r_s3_aligned <= '0;
      else if (r_s2_sign) r_s3_aligned <= -r_s2_shifted;
      else                r_s3_aligned <= r_s2_shifted;
    end
  end

  // Quire, sticky NaR and term count; all clear when the result is taken
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_quire <= '0;
      r_nar   <= 1'b0;
      r_count <= '0;
    end else if (w_out_xfer) begin
      r_quire <= '0;
      r_nar   <= 1'b0;
      r_count <= '0;
    end else begin
      if (r_s3_valid) begin
        r_quire <= r_quire + r_s3_aligned;
        r_nar   <= r_nar | r_s3_nar;
      end
      if (w_in_xfer) r_count <= r_count + 1'b1;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_quire = r_quire;
  assign bus.out_nar   = r_nar;
  assign bus.out_count = r_count;

endmodule
`default_nettype wire
